pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_ctrl_md_sequencer.sv | 63 ++++++
 rtl/pipe_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and forwarding encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    MW_IDLE = 1'b0,
    MW_WAIT = 1'b1
  } mw_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  // M-stage result is younger than W-stage, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       rw_m,
                                         input logic [4:0] wr_m,
                                         input logic       rw_w,
                                         input logic [4:0] wr_w);
    if (src != 5'd0 && rw_m && wr_m == src) return FWD_M;
    if (src != 5'd0 && rw_w && wr_w == src) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_md_sequencer.sv
// Mult/div latency sequencer: a down-counter timing the iterative unit.
//   state   | meaning
//   MD_IDLE | no operation in flight
//   MD_BUSY | counting down remaining cycles
//   MD_DONE | result ready this cycle; a new start is accepted here
module md_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  md_state_t  state;
  logic [5:0] md_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      md_cnt <= 6'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        MD_IDLE, MD_DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= MD_BUSY;
            md_cnt <= is_div ? DIV_LOAD : MUL_LOAD;
            busy   <= 1'b1;
          end else begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
        end
        MD_BUSY: begin
          if (md_cnt == 6'd0) begin
            state <= MD_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            md_cnt <= md_cnt - 6'd1;
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard unit: forwarding selects, stall/flush generation,
// mult/div interlock and data-memory wait handling.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic       reg_write_e,
  input  logic       mem_to_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_m,
  input  logic       mem_to_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_w,
  input  logic       branch_d,
  input  logic       md_start_e,
  input  logic       md_div_e,
  input  logic       md_read_d,
  input  logic       dmem_req_m,
  input  logic       dmem_ack,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_e,
  output logic       flush_w,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       md_busy,
  output logic       md_done
);

  mw_state_t mw_state;
  logic      seq_busy, seq_done;
  logic      mem_stall, load_use, branch_haz, md_read_haz, md_issue_haz;
  logic      hold_fd, hold_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      mw_state <= MW_IDLE;
    end else begin
      case (mw_state)
        MW_IDLE: if (dmem_req_m && !dmem_ack) mw_state <= MW_WAIT;
        MW_WAIT: if (dmem_ack) mw_state <= MW_IDLE;
        default: mw_state <= MW_IDLE;
      endcase
    end
  end

  md_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .rst   (rst),
    .start (md_start_e && !hold_e),
    .is_div(md_div_e),
    .busy  (seq_busy),
    .done  (seq_done)
  );

  always_comb begin
    mem_stall    = dmem_req_m && !dmem_ack;
    load_use     = mem_to_reg_e && write_reg_e != 5'd0 &&
                   (write_reg_e == rs_d || write_reg_e == rt_d);
    branch_haz   = branch_d &&
                   ((reg_write_e && write_reg_e != 5'd0 &&
                     (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                    (mem_to_reg_m && write_reg_m != 5'd0 &&
                     (write_reg_m == rs_d || write_reg_m == rt_d)));
    md_read_haz  = md_read_d && (seq_busy || md_start_e);
    md_issue_haz = md_start_e && seq_busy;
    hold_e       = md_issue_haz || mem_stall;
    hold_fd      = hold_e || load_use || branch_haz || md_read_haz;
  end

  // Everything is forced quiet while rst is high; a held E stage is never flushed.
  always_comb begin
    stall_f = !rst && hold_fd;
    stall_d = !rst && hold_fd;
    stall_e = !rst && hold_e;
    stall_m = !rst && mem_stall;
    flush_w = !rst && mem_stall;
    flush_e = !rst && !hold_e && (load_use || branch_haz || md_read_haz);
    fwd_a_e = rst ? FWD_RF : fwd_sel(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    fwd_b_e = rst ? FWD_RF : fwd_sel(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    fwd_a_d = !rst && reg_write_m && write_reg_m != 5'd0 && write_reg_m == rs_d;
    fwd_b_d = !rst && reg_write_m && write_reg_m != 5'd0 && write_reg_m == rt_d;
    md_busy = !rst && seq_busy;
    md_done = !rst && seq_done;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-count reference model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, reg_write_w;
  logic branch_d, md_start_e, md_div_e, md_read_d, dmem_req_m, dmem_ack;
  logic stall_f, stall_d, stall_e, stall_m, flush_e, flush_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic fwd_a_d, fwd_b_d, md_busy, md_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: remaining busy cycles and a done flag.
  int   md_left = 0;
  logic md_done_m = 1'b0;
  logic [13:0] last_outs;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .branch_d(branch_d), .md_start_e(md_start_e), .md_div_e(md_div_e),
    .md_read_d(md_read_d), .dmem_req_m(dmem_req_m), .dmem_ack(dmem_ack),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .md_busy(md_busy), .md_done(md_done)
  );

  wire [13:0] outs = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_w,
                      fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, md_busy, md_done};

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (reg_write_m && write_reg_m == src) return 2'b10;
    if (reg_write_w && write_reg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [13:0] model_out();
    logic busy, ld, br, rd, iss, mem, sf, se, fe;
    logic [4:0] srcs [2];
    if (rst) return 14'd0;
    busy = md_left > 0;
    srcs[0] = rs_d; srcs[1] = rt_d;
    ld = 0; br = 0;
    foreach (srcs[k]) begin
      if (srcs[k] != 0 && mem_to_reg_e && write_reg_e == srcs[k]) ld = 1;
      if (srcs[k] != 0 && branch_d && reg_write_e && write_reg_e == srcs[k]) br = 1;
      if (srcs[k] != 0 && branch_d && mem_to_reg_m && write_reg_m == srcs[k]) br = 1;
    end
    rd  = md_read_d && (busy || md_start_e);
    iss = md_start_e && busy;
    mem = dmem_req_m && !dmem_ack;
    se  = iss || mem;
    sf  = se || ld || br || rd;
    fe  = !se && (ld || br || rd);
    return {sf, sf, se, mem, fe, mem, ref_fwd(rs_e), ref_fwd(rt_e),
            reg_write_m && write_reg_m != 0 && write_reg_m == rs_d,
            reg_write_m && write_reg_m != 0 && write_reg_m == rt_d,
            busy, md_done_m};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Check at negedge against the model, then advance the model through the edge.
  task automatic cycle(input string name);
    logic [13:0] e;
    @(negedge clk);
    e = model_out();
    last_outs = outs;
    chk(name, outs, e);
    if (rst) begin
      md_left = 0; md_done_m = 0;
    end else if (md_start_e && !e[11] && md_left == 0) begin
      md_left = md_div_e ? 32 : 4; md_done_m = 0;
    end else if (md_left > 0) begin
      md_left--; md_done_m = (md_left == 0);
    end else begin
      md_done_m = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, reg_write_w} = '0;
    {branch_d, md_start_e, md_div_e, md_read_d, dmem_req_m, dmem_ack} = '0;
  endtask

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e;
    logic rw_e, m2r_e;
    logic [4:0] wr_m;
    logic rw_m, m2r_m;
    logic [4:0] wr_w;
    logic rw_w, br;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int nbusy, done_at, ndone;
    // rs_d rt_d rs_e rt_e wr_e rw_e m2r_e wr_m rw_m m2r_m wr_w rw_w br exp
    vecs[0]  = '{0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 5, 1, 0, {6'b0, 2'b10, 2'b00, 4'b0000}};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 1, 0, {6'b0, 2'b00, 2'b00, 4'b0000}};
    vecs[2]  = '{0, 0, 0, 7, 0, 0, 0, 3, 1, 0, 7, 1, 0, {6'b0, 2'b00, 2'b01, 4'b0000}};
    vecs[3]  = '{0, 0, 9, 9, 0, 0, 0, 9, 1, 0, 9, 1, 0, {6'b0, 2'b10, 2'b10, 4'b0000}};
    vecs[4]  = '{0, 0, 4, 0, 0, 0, 0, 4, 0, 0, 4, 0, 0, {6'b0, 2'b00, 2'b00, 4'b0000}};
    vecs[5]  = '{6, 6, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, {6'b0, 2'b00, 2'b00, 4'b1100}};
    vecs[6]  = '{0, 8, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, {6'b110010, 4'b0, 4'b0000}};
    vecs[7]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, {6'b0, 4'b0, 4'b0000}};
    vecs[8]  = '{3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, {6'b110010, 4'b0, 4'b0000}};
    vecs[9]  = '{0, 12, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1, {6'b110010, 4'b0, 4'b0100}};
    vecs[10] = '{12, 0, 0, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1, {6'b0, 4'b0, 4'b1000}};

    clear_inputs();
    // Reset with hazard-provoking inputs: everything must stay quiet.
    rst = 1; mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8; reg_write_m = 1;
    write_reg_m = 5; rs_e = 5; dmem_req_m = 1; md_start_e = 1;
    cycle("reset_quiet");
    chk("reset_zero", last_outs, 14'd0);
    cycle("reset_quiet2");
    rst = 0; clear_inputs();
    cycle("idle");

    foreach (vecs[i]) begin
      clear_inputs();
      rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d; rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
      write_reg_e = vecs[i].wr_e; reg_write_e = vecs[i].rw_e; mem_to_reg_e = vecs[i].m2r_e;
      write_reg_m = vecs[i].wr_m; reg_write_m = vecs[i].rw_m; mem_to_reg_m = vecs[i].m2r_m;
      write_reg_w = vecs[i].wr_w; reg_write_w = vecs[i].rw_w; branch_d = vecs[i].br;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Load-use stalls one cycle then clears once a bubble reaches E.
    clear_inputs();
    mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8;
    cycle("loaduse_hit");
    chk("loaduse_stall", last_outs[13:8], 6'b110010);
    mem_to_reg_e = 0; write_reg_e = 0;
    cycle("loaduse_clear");
    chk("loaduse_gone", last_outs[13:8], 6'b000000);

    // Divide with mfhi/mflo held in decode.
    clear_inputs();
    md_start_e = 1; md_div_e = 1; md_read_d = 1;
    cycle("div_issue");
    chk("div_issue_stall", last_outs[13:8], 6'b110010);
    md_start_e = 0;
    nbusy = 0; done_at = 0;
    for (int i = 1; i <= 36; i++) begin
      cycle("div_run");
      if (last_outs[1]) nbusy++;
      if (last_outs[0] && done_at == 0) begin
        done_at = i;
        chk("div_done_nostall", {13'd0, last_outs[13]}, 14'd0);
      end
    end
    chk_int("div_busy_cycles", nbusy, 32);
    chk_int("div_done_cycle", done_at, 33);

    // Memory wait of three cycles overlapping a multiply.
    clear_inputs();
    md_start_e = 1;
    cycle("mul_issue");
    md_start_e = 0; dmem_req_m = 1;
    for (int i = 1; i <= 3; i++) begin
      cycle("memwait");
      chk("memwait_stall_m_flush_w", {12'd0, last_outs[10], last_outs[8]}, 14'b11);
    end
    dmem_ack = 1;
    cycle("memwait_ack");
    chk("memack_nostall", {12'd0, last_outs[10], last_outs[8]}, 14'b00);
    dmem_req_m = 0; dmem_ack = 0;
    cycle("mul_done");
    chk("mul_done_on_time", {13'd0, last_outs[0]}, 14'd1);

    // Reset in the middle of a divide abandons it.
    clear_inputs();
    md_start_e = 1; md_div_e = 1;
    cycle("div2_issue");
    md_start_e = 0;
    for (int i = 1; i < 10; i++) cycle("div2_run");
    rst = 1;
    cycle("div2_rst");
    rst = 0;
    cycle("div2_after_rst");
    chk("div2_busy_cleared", {13'd0, last_outs[1]}, 14'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("div2_quiet");
      if (last_outs[0]) ndone++;
    end
    chk_int("div2_no_done", ndone, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      write_reg_e = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
      write_reg_w = 5'($urandom_range(0, 3));
      reg_write_e = 1'($urandom); mem_to_reg_e = 1'($urandom);
      reg_write_m = 1'($urandom); mem_to_reg_m = 1'($urandom); reg_write_w = 1'($urandom);
      branch_d = 1'($urandom);
      md_start_e = ($urandom_range(0, 7) == 0);
      md_div_e = 1'($urandom);
      md_read_d = ($urandom_range(0, 3) == 0);
      dmem_req_m = ($urandom_range(0, 3) == 0);
      dmem_ack = 1'($urandom);
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
